// File: rtl/io_pkg.sv
// io_pkg: shared constants and helpers for the cpu I/O port bridge.
//   IO_BASE_SEL      : value of mem_a[17:16] that selects the I/O window
//   OFF_UART/OFF_CNT : byte offsets (mem_a[2:0]) of the UART data and counter/stop registers
//   TX_DEPTH_DEF     : default TX FIFO depth
//   FULL_MARGIN_DEF  : default free-slot slack for io_buffer_full
//   io_off_t         : byte offset type
//   snap_byte()      : selects byte off[1:0] of a 32-bit word
package io_pkg;

  localparam logic [1:0] IO_BASE_SEL = 2'b11;

  typedef logic [2:0] io_off_t;

  localparam io_off_t OFF_UART = 3'd0;
  localparam io_off_t OFF_CNT  = 3'd4;

  localparam int TX_DEPTH_DEF    = 16;
  localparam int FULL_MARGIN_DEF = 2;

  // Offsets 4..7 map onto bytes 0..3 of the counter word.
  function automatic logic [7:0] snap_byte(input logic [31:0] v, input io_off_t off);
    return v[{off[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: single-clock FIFO buffering UART TX bytes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : enqueue i_data (accepted when not full, or when a pop frees a slot)
//   i_pop       : consumer takes the head byte (ignored when empty)
//   o_data      : head byte
//   o_full      : all DEPTH entries used
//   o_empty     : no entries
//   o_count     : occupancy, 0..DEPTH
module io_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH[AW:0]);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A pop in the same cycle frees the slot first, so a push at full still lands.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: memory-mapped I/O slave on the cpu byte bus.
// Accesses with mem_a[17:16]==2'b11 (and rdy_in=1) are decoded on mem_a[2:0]:
//   write off 0 : enqueue mem_dout to the UART TX FIFO (0x00 is filtered out)
//   write off 4 : enqueue 0x00 and set the sticky program_done flag
//   read  off 0 : UART RX byte (0x00 when none), pops rx_data
//   read  off 4 : cycle_cnt[7:0], and snapshots the full counter
//   read  off 5..7 : snapshot bytes 1..3
// Read data appears on io_din one cycle after the read, flagged by io_sel.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in, mem_a, mem_dout, mem_wr : cpu side
//   io_sel, io_din, io_buffer_full                                    : cpu return path
//   tx_data, tx_valid, tx_ready                                       : UART TX
//   rx_data, rx_valid, rx_pop                                         : UART RX
//   program_done                                                      : sticky stop flag
// Optional macro IO_LOOPBACK_EN: bytes sent to the UART are also captured in a
// one-entry RX holding register, which offset-0 reads consume ahead of rx_data.
module io_port_bridge
  import io_pkg::*;
#(
  parameter int TX_DEPTH    = TX_DEPTH_DEF,
  parameter int FULL_MARGIN = FULL_MARGIN_DEF,
  parameter int CNT_W       = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_sel,
  output logic [7:0]  io_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done
);

  localparam int AW = $clog2(TX_DEPTH);

  logic             w_acc;
  io_off_t          w_off;
  logic             w_wr_data;
  logic             w_wr_stop;
  logic             w_push;
  logic [7:0]       w_push_byte;
  logic             w_rd;
  logic             w_rd_uart;
  logic             w_deq;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [AW:0]      w_free;
  logic             w_use_hold;
  logic [7:0]       w_hold;
  logic [7:0]       w_rd_byte;
  logic             w_unused;

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_snapshot;
  logic [15:0]      r_drop_cnt;

  assign w_acc     = rdy_in && (mem_a[17:16] == IO_BASE_SEL);
  assign w_off     = mem_a[2:0];
  assign w_wr_data = w_acc && mem_wr && (w_off == OFF_UART) && (mem_dout != 8'h00);
  assign w_wr_stop = w_acc && mem_wr && (w_off == OFF_CNT);
  assign w_push    = w_wr_data || w_wr_stop;
  // The stop marker is a literal 0x00 that must reach the UART despite the zero filter.
  assign w_push_byte = w_wr_stop ? 8'h00 : mem_dout;
  assign w_rd      = w_acc && !mem_wr;
  assign w_rd_uart = w_rd && (w_off == OFF_UART);
  assign w_deq     = tx_valid && tx_ready;

  io_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .i_push  (w_push),
    .i_pop   (tx_ready),
    .i_data  (w_push_byte),
    .o_data  (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign tx_valid = !w_empty;

  // Slack of FULL_MARGIN slots absorbs cpu writes already issued when the flag rises.
  assign w_free         = TX_DEPTH[AW:0] - w_count;
  assign io_buffer_full = (w_free <= FULL_MARGIN[AW:0]);

`ifdef IO_LOOPBACK_EN
  logic       r_hold_vld;
  logic [7:0] r_hold;

  assign w_use_hold = r_hold_vld;
  assign w_hold     = r_hold;

  // A byte leaving for the UART overwrites the holder even if a read consumes it this cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hold_vld <= 1'b0;
    end else if (w_deq) begin
      r_hold_vld <= 1'b1;
    end else if (w_rd_uart) begin
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_deq) r_hold <= tx_data;
  end
`else
  assign w_use_hold = 1'b0;
  assign w_hold     = 8'h00;
`endif

  // Gated by rst_in so the UART never sees a pop while the bridge is held in reset.
  assign rx_pop = rst_in && w_rd_uart && rx_valid && !w_use_hold;

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_off == OFF_UART) begin
      w_rd_byte = w_use_hold ? w_hold : (rx_valid ? rx_data : 8'h00);
    end else if (w_off == OFF_CNT) begin
      w_rd_byte = r_cycle_cnt[7:0];
    end else if (w_off[2]) begin
      // Upper bytes come from the snapshot so a 4..7 read sequence is coherent.
      w_rd_byte = snap_byte(r_snapshot, w_off);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_sel       <= 1'b0;
      io_din       <= 8'h00;
      program_done <= 1'b0;
      r_cycle_cnt  <= '0;
      r_snapshot   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      io_sel <= w_rd;
      if (w_rd) io_din <= w_rd_byte;
      if (rdy_in) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_rd && (w_off == OFF_CNT)) r_snapshot <= r_cycle_cnt;
      if (w_wr_stop) program_done <= 1'b1;
      if (w_push && w_full && !w_deq) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Address bits outside the decode and the debug drop counter have no consumer here.
  assign w_unused = ^{mem_a[31:18], mem_a[15:3], r_drop_cnt};

endmodule
